regfile_wb_arbiter: RTL and testbench

Controller for the single write port of the 32x32 register file. Shares that port between two writeback requesters: the ALU result path and the load/memory path. Optionally sequences a clear of every register after reset. Drives RegWr/RD/WData of the register file from registered outputs; read ports are untouched.

---
 rtl/regfile_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: arbitrates ALU and load
// writebacks round-robin. Optional post-reset clear under RF_INIT_CLEAR_EN.
module regfile_wb_arbiter #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                NUM_REGS   = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WbHold,
    input  logic              AluReq,
    input  logic [ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluAck,
    input  logic              MemReq,
    input  logic [ADDR_W-1:0] MemRd,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemAck,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RD,
    output logic [DATA_W-1:0] WData,
    output logic              Busy
);

    typedef enum logic { INIT, RUN } state_t;
    typedef enum logic { PTR_ALU, PTR_MEM } ptr_t;

    state_t            state, state_nxt;
    ptr_t              ptr, ptr_nxt;
    logic              wr_nxt;
    logic [ADDR_W-1:0] rd_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              run_ok;
    logic              alu_win;
    logic              mem_win;

`ifdef RF_INIT_CLEAR_EN
    localparam state_t            RESET_STATE = INIT;
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);
    logic [ADDR_W-1:0] idx, idx_nxt;
`else
    localparam state_t RESET_STATE = RUN;
`endif

    // Reject configurations the clear sequence or write port cannot cover
    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W) ||
        $bits(INIT_VALUE) != DATA_W) begin : g_bad_cfg
        $error("regfile_wb_arbiter: bad NUM_REGS/ADDR_W/INIT_VALUE");
    end

    // Grant: pointer breaks ties, only in RUN and when not stalled
    always_comb begin
        run_ok  = (state == RUN) && !WbHold;
        alu_win = AluReq && (!MemReq || ptr == PTR_ALU);
        mem_win = MemReq && (!AluReq || ptr == PTR_MEM);
        AluAck  = run_ok && alu_win;
        MemAck  = run_ok && mem_win;
    end

`ifdef RF_INIT_CLEAR_EN
    assign Busy = (state == INIT);
`else
    assign Busy = 1'b0;
`endif

    // Next state, pointer and write-port values
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wr_nxt    = 1'b0;
        rd_nxt    = RD;
        wdata_nxt = WData;
`ifdef RF_INIT_CLEAR_EN
        idx_nxt   = idx;
`endif
        unique case (state)
            INIT: begin
`ifdef RF_INIT_CLEAR_EN
                wr_nxt    = 1'b1;
                rd_nxt    = idx;
                wdata_nxt = INIT_VALUE;
                idx_nxt   = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = RUN;
                end
`endif
            end
            RUN: begin
                unique case (1'b1)
                    AluAck: begin
                        ptr_nxt   = PTR_MEM;
                        wr_nxt    = (AluRd != '0);
                        rd_nxt    = AluRd;
                        wdata_nxt = AluData;
                    end
                    MemAck: begin
                        ptr_nxt   = PTR_ALU;
                        wr_nxt    = (MemRd != '0);
                        rd_nxt    = MemRd;
                        wdata_nxt = MemData;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State and registered write-port outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RESET_STATE;
            ptr   <= PTR_ALU;
            RegWr <= 1'b0;
            RD    <= '0;
            WData <= '0;
`ifdef RF_INIT_CLEAR_EN
            idx   <= ADDR_W'(1);
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            RegWr <= wr_nxt;
            RD    <= rd_nxt;
            WData <= wdata_nxt;
`ifdef RF_INIT_CLEAR_EN
            idx   <= idx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with a write-port scoreboard,
// plus the clear sequence and mid-clear reset when RF_INIT_CLEAR_EN is set.
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        WbHold;
    logic        AluReq;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        AluAck;
    logic        MemReq;
    logic [4:0]  MemRd;
    logic [31:0] MemData;
    logic        MemAck;
    logic        RegWr;
    logic [4:0]  RD;
    logic [31:0] WData;
    logic        Busy;

    regfile_wb_arbiter dut (
        .Clk(Clk), .Reset(Reset), .WbHold(WbHold),
        .AluReq(AluReq), .AluRd(AluRd), .AluData(AluData), .AluAck(AluAck),
        .MemReq(MemReq), .MemRd(MemRd), .MemData(MemData), .MemAck(MemAck),
        .RegWr(RegWr), .RD(RD), .WData(WData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        areq;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mreq;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        ea;
        logic        em;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        full;
    } exp_t;

    localparam int NV = 24;
    vec_t        tbl[NV];
    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_d;
    logic        known;

    function automatic vec_t v(input logic rst, input logic hold,
                               input logic areq, input logic [4:0] ard,
                               input logic [31:0] adata, input logic mreq,
                               input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic ea, input logic em);
        vec_t r;
        r.rst = rst; r.hold = hold;
        r.areq = areq; r.ard = ard; r.adata = adata;
        r.mreq = mreq; r.mrd = mrd; r.mdata = mdata;
        r.ea = ea; r.em = em;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int i);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty vec %0d got none want entry", i);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("regwr v%0d", i), {31'b0, RegWr}, {31'b0, e.wr});
            if (e.full) begin
                chk($sformatf("rd v%0d", i), {27'b0, RD}, {27'b0, e.rd});
                chk($sformatf("wdata v%0d", i), WData, e.d);
            end
        end
    endtask

    task automatic drive(input vec_t t);
        Reset   = t.rst;
        WbHold  = t.hold;
        AluReq  = t.areq;
        AluRd   = t.ard;
        AluData = t.adata;
        MemReq  = t.mreq;
        MemRd   = t.mrd;
        MemData = t.mdata;
    endtask

    task automatic push_exp(input vec_t t);
        exp_t e;
        if (t.rst) begin
            e = '{1'b0, 5'd0, 32'd0, 1'b1};
            last_rd = 5'd0; last_d = 32'd0; known = 1'b1;
        end else if (t.ea || t.em) begin
            logic [4:0]  r;
            logic [31:0] d;
            r = t.ea ? t.ard : t.mrd;
            d = t.ea ? t.adata : t.mdata;
            if (r != 5'd0) begin
                e = '{1'b1, r, d, 1'b1};
                last_rd = r; last_d = d; known = 1'b1;
            end else begin
                e = '{1'b0, 5'd0, 32'd0, 1'b0};
                known = 1'b0;
            end
        end else begin
            e = '{1'b0, last_rd, last_d, known};
        end
        sbq.push_back(e);
    endtask

    // Clear sequence starting at the first falling edge after reset
    task automatic init_seq(input int upto);
        for (int k = 0; k <= upto; k++) begin
            if (k > 0) @(negedge Clk);
            if (k == 0) begin
                Reset = 1'b0; WbHold = 1'b0;
                AluReq = 1'b1; AluRd = 5'd7; AluData = 32'h7;
                MemReq = 1'b1; MemRd = 5'd8; MemData = 32'h8;
            end
            #1;
            if (k < 31) begin
                chk("init_busy", {31'b0, Busy}, 32'd1);
                chk("init_aluack", {31'b0, AluAck}, 32'd0);
                chk("init_memack", {31'b0, MemAck}, 32'd0);
            end else begin
                chk("init_done_busy", {31'b0, Busy}, 32'd0);
                chk("first_aluack", {31'b0, AluAck}, 32'd1);
                chk("first_memack", {31'b0, MemAck}, 32'd0);
            end
            if (k > 0) begin
                chk("init_regwr", {31'b0, RegWr}, 32'd1);
                chk("init_rd", {27'b0, RD}, k);
                chk("init_wdata", WData, 32'd0);
            end
        end
        if (upto == 31) begin
            AluReq = 1'b0;
            MemReq = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst hold areq ard    adata          mreq mrd    mdata     ea em
        tbl[0]  = v(1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    0, 0);
        tbl[1]  = v(0, 0, 1, 5'd5,  32'hDEAD_BEEF, 0, 5'd0,  32'h0,    1, 0);
        tbl[2]  = v(0, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    0, 0);
        tbl[3]  = v(1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    0, 0);
        tbl[4]  = v(0, 0, 1, 5'd3,  32'h1,         1, 5'd4,  32'h2,    1, 0);
        tbl[5]  = v(0, 0, 1, 5'd3,  32'h11,        1, 5'd4,  32'h2,    0, 1);
        tbl[6]  = v(0, 0, 1, 5'd3,  32'h11,        1, 5'd4,  32'h22,   1, 0);
        tbl[7]  = v(0, 0, 1, 5'd3,  32'h33,        1, 5'd4,  32'h22,   0, 1);
        tbl[8]  = v(0, 0, 1, 5'd3,  32'h33,        0, 5'd0,  32'h0,    1, 0);
        tbl[9]  = v(0, 1, 1, 5'd6,  32'h66,        1, 5'd7,  32'h77,   0, 0);
        tbl[10] = v(0, 1, 1, 5'd6,  32'h66,        1, 5'd7,  32'h77,   0, 0);
        tbl[11] = v(0, 1, 1, 5'd6,  32'h66,        1, 5'd7,  32'h77,   0, 0);
        tbl[12] = v(0, 0, 1, 5'd6,  32'h66,        1, 5'd7,  32'h77,   0, 1);
        tbl[13] = v(0, 0, 1, 5'd6,  32'h66,        0, 5'd0,  32'h0,    1, 0);
        tbl[14] = v(0, 0, 0, 5'd0,  32'h0,         1, 5'd0,  32'h1234, 0, 1);
        tbl[15] = v(0, 0, 1, 5'd9,  32'h99,        1, 5'd10, 32'hAA,   1, 0);
        tbl[16] = v(0, 0, 1, 5'd9,  32'h999,       1, 5'd10, 32'hAA,   0, 1);
        tbl[17] = v(0, 0, 1, 5'd9,  32'h999,       0, 5'd0,  32'h0,    1, 0);
        tbl[18] = v(0, 0, 1, 5'd12, 32'hC,         0, 5'd0,  32'h0,    1, 0);
        tbl[19] = v(1, 0, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,    0, 0);
        tbl[20] = v(0, 0, 1, 5'd31, 32'hFFFF_FFFF, 1, 5'd1,  32'h5,    1, 0);
        tbl[21] = v(0, 0, 1, 5'd2,  32'h22,        1, 5'd1,  32'h5,    0, 1);
        tbl[22] = v(0, 1, 1, 5'd2,  32'h22,        0, 5'd0,  32'h0,    0, 0);
        tbl[23] = v(0, 0, 1, 5'd2,  32'h22,        0, 5'd0,  32'h0,    1, 0);

        last_rd = 5'd0; last_d = 32'd0; known = 1'b0;
        Reset = 1'b1; WbHold = 1'b0;
        AluReq = 1'b0; AluRd = 5'd0; AluData = 32'd0;
        MemReq = 1'b0; MemRd = 5'd0; MemData = 32'd0;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge Clk);
            if (i > 0) pop_check(i - 1);
`ifdef RF_INIT_CLEAR_EN
            if (i > 0 && tbl[i-1].rst) begin
                init_seq(31);
                last_rd = 5'd31; last_d = 32'd0; known = 1'b1;
            end
`endif
            drive(tbl[i]);
            #1;
            chk($sformatf("aluack v%0d", i), {31'b0, AluAck}, {31'b0, tbl[i].ea});
            chk($sformatf("memack v%0d", i), {31'b0, MemAck}, {31'b0, tbl[i].em});
            if (!tbl[i].rst)
                chk($sformatf("busy v%0d", i), {31'b0, Busy}, 32'd0);
            push_exp(tbl[i]);
        end
        @(negedge Clk);
        pop_check(NV - 1);

`ifdef RF_INIT_CLEAR_EN
        // Reset while the clear is at index 10 restarts at register 1
        Reset = 1'b1;
        @(negedge Clk);
        init_seq(9);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midinit_regwr", {31'b0, RegWr}, 32'd0);
        chk("midinit_rd", {27'b0, RD}, 32'd0);
        init_seq(31);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
